// File: rtl/fila_escrita.sv
// Write-back queue between the execute stages and the register bank: buffers
// pending writes in order, drains one per cycle, and bypasses pending values to readers.
module fila_escrita #(
    parameter int PROFUNDIDADE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        bloqueio,
    output logic        regWrite,
    output logic [4:0]  escrita,
    output logic [31:0] dataWrite,
    input  logic [4:0]  leitura1,
    input  logic [4:0]  leitura2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] dado1,
    output logic [31:0] dado2,
    output logic [4:0]  ocupacao
);

    localparam int PTR_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [4:0] CAPACIDADE = 5'(PROFUNDIDADE);

    logic [4:0]       regMem  [PROFUNDIDADE];
    logic [31:0]      dataMem [PROFUNDIDADE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [4:0]       count;
    logic             push;
    logic             pop;

    assign ocupacao = count;

    // Readiness depends only on registered occupancy, so a full queue refuses
    // a request even when the head is leaving on the same edge.
    assign in_ready = !reset && (count < CAPACIDADE);
    assign push     = in_valid && in_ready && (in_reg != 5'd0);
    assign pop      = (count != 5'd0) && !bloqueio && !reset;

    always_comb begin
        regWrite  = 1'b0;
        escrita   = 5'd0;
        dataWrite = 32'd0;
        if (pop) begin
            regWrite  = 1'b1;
            escrita   = regMem[head];
            dataWrite = dataMem[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 5'd0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            regMem[tail]  <= in_reg;
            dataMem[tail] <= in_data;
        end
    end

    // Walk from oldest to youngest so the last match found is the newest value.
    function automatic logic [32:0] procura(input logic [4:0] addr);
        logic [32:0]      res;
        logic [PTR_W-1:0] idx;
        res = 33'd0;
        idx = '0;
        if (addr != 5'd0) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                idx = head + PTR_W'(i);
                if ((5'(i) < count) && (regMem[idx] == addr)) begin
                    res = {1'b1, dataMem[idx]};
                end
            end
        end
        return res;
    endfunction

    assign {hit1, dado1} = procura(leitura1);
    assign {hit2, dado2} = procura(leitura2);

endmodule

// File: tb/tb_fila_escrita.sv
// Randomized and directed bench for fila_escrita: a queue-based reference model
// predicts every output and a negedge monitor compares against the DUT.
module tb_fila_escrita;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        in_ready;
    logic        bloqueio;
    logic        regWrite;
    logic [4:0]  escrita;
    logic [31:0] dataWrite;
    logic [4:0]  leitura1;
    logic [4:0]  leitura2;
    logic        hit1;
    logic        hit2;
    logic [31:0] dado1;
    logic [31:0] dado2;
    logic [4:0]  ocupacao;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int writeCount = 0;
    bit checking   = 1'b0;

    entry_t pend[$];

    fila_escrita #(.PROFUNDIDADE(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data), .in_ready(in_ready),
        .bloqueio(bloqueio),
        .regWrite(regWrite), .escrita(escrita), .dataWrite(dataWrite),
        .leitura1(leitura1), .leitura2(leitura2),
        .hit1(hit1), .hit2(hit2), .dado1(dado1), .dado2(dado2),
        .ocupacao(ocupacao)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Youngest pending entry for a read address, searched from the tail end.
    function automatic logic [32:0] bypassModel(input logic [4:0] addr);
        logic [32:0] res;
        res = 33'd0;
        if (addr != 5'd0) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].r == addr) begin
                    res = {1'b1, pend[i].d};
                    break;
                end
            end
        end
        return res;
    endfunction

    // Monitor: compare this cycle's outputs, then advance the model to the next edge.
    always @(negedge clk) begin
        if (checking) begin
            logic        expReady;
            logic        expPop;
            logic [32:0] b1;
            logic [32:0] b2;
            entry_t      head;
            expReady = !reset && (pend.size() < DEPTH);
            expPop   = !reset && !bloqueio && (pend.size() > 0);
            b1 = bypassModel(leitura1);
            b2 = bypassModel(leitura2);
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
            checkOutput("ocupacao", {27'd0, ocupacao}, 32'(pend.size()));
            checkOutput("regWrite", {31'd0, regWrite}, {31'd0, expPop});
            checkOutput("hit1", {31'd0, hit1}, {31'd0, b1[32]});
            checkOutput("dado1", dado1, b1[31:0]);
            checkOutput("hit2", {31'd0, hit2}, {31'd0, b2[32]});
            checkOutput("dado2", dado2, b2[31:0]);
            if (regWrite === 1'b1 && pend.size() > 0) begin
                head = pend.pop_front();
                writeCount++;
                checkOutput("escrita", {27'd0, escrita}, {27'd0, head.r});
                checkOutput("dataWrite", dataWrite, head.d);
            end else begin
                if (expPop) begin
                    void'(pend.pop_front());
                end
                if (regWrite !== 1'b1) begin
                    checkOutput("escrita_idle", {27'd0, escrita}, 32'd0);
                    checkOutput("dataWrite_idle", dataWrite, 32'd0);
                end
            end
            if (reset) begin
                pend.delete();
            end else if (in_valid && expReady && in_reg != 5'd0) begin
                pend.push_back('{r: in_reg, d: in_data});
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] r, input logic [31:0] d,
                                 input logic bl, input logic [4:0] l1, input logic [4:0] l2);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        bloqueio = bl;
        leitura1 = l1;
        leitura2 = l2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
        bloqueio = 1'b0; leitura1 = 5'd0; leitura2 = 5'd0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h1234, 1'b0, 5'd4, 5'd0);
        reset = 1'b0;

        // Single write drains the next cycle.
        applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd5, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);

        // Fill under bloqueio, same register written several times.
        applyStimulus(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 5'd7);
        applyStimulus(1'b1, 5'd3, 32'd2, 1'b1, 5'd3, 5'd7);
        applyStimulus(1'b1, 5'd7, 32'd9, 1'b1, 5'd3, 5'd7);
        applyStimulus(1'b1, 5'd3, 32'd3, 1'b1, 5'd3, 5'd7);
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd3, 5'd7);

        // Release with a request held while full.
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd3, 5'd9);
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd3, 5'd9);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd9);

        // Writes to r0 are dropped.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        // Streaming push+pop wraps the pointers.
        for (int i = 1; i <= 10; i++)
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'(i), 5'(i - 1));
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd0);

        // Reset with pending entries loses them.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 5'(20 + i), 32'hDEAD_0000 + 32'(i), 1'b1, 5'd20, 5'd22);
        reset = 1'b1;
        applyStimulus(1'b1, 5'd23, 32'hBAD, 1'b0, 5'd20, 5'd22);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 5'd22);

        // Random traffic with small register numbers to provoke bypass hits.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            applyStimulus($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        checkOutput("writes_seen", 32'(writeCount > 20), 32'd1);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
